// File: rtl/fab_clk_lock_supervisor.sv
// fab_clk_lock_supervisor: qualifies CCC lock into fabric reset/ready and tracks lock-loss events
module fab_clk_lock_supervisor #(
  parameter int LOCK_FILTER = 16,
  parameter int RST_HOLD = 32,
  parameter int LOSS_CNT_W = 8
) (
  input  logic                  FAB_CLK,
  input  logic                  FAB_RST,
  input  logic                  LOCK,
  input  logic                  BYPASS_LOCK,
  input  logic                  CLR_LOSS,
  output logic                  SYS_RST,
  output logic                  SYS_READY,
  output logic                  LOCK_LOST,
  output logic [LOSS_CNT_W-1:0] LOSS_COUNT,
  output logic [1:0]            STATE
);
  localparam int CW = $clog2(LOCK_FILTER > RST_HOLD ? LOCK_FILTER : RST_HOLD) + 1;
  typedef enum logic [1:0] {FILTER = 2'd0, HOLD = 2'd1, RUN = 2'd2, BAD = 2'd3} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] sync;
  logic lock_s, loss;
  assign lock_s = sync[1];
  assign SYS_RST = state != RUN;
  assign SYS_READY = ~SYS_RST;
  assign STATE = state;
  always_ff @(posedge FAB_CLK) begin
    if (FAB_RST) begin
      sync <= '0;
      state <= FILTER;
      cnt <= '0;
    end else begin
      sync <= {sync[0], LOCK | BYPASS_LOCK};
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    loss = 1'b0;
    case (state)
      FILTER: begin
        cnt_n = lock_s ? cnt + 1'b1 : '0;
        if (lock_s && cnt == CW'(LOCK_FILTER - 1)) begin
          state_n = HOLD;
          cnt_n = '0;
        end
      end
      HOLD: begin
        cnt_n = cnt + 1'b1;
        if (!lock_s) begin
          state_n = FILTER;
          cnt_n = '0;
        end else if (cnt == CW'(RST_HOLD - 1)) begin
          state_n = RUN;
          cnt_n = '0;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_n = FILTER;
          cnt_n = '0;
          loss = 1'b1;
        end
      end
      default: begin
        state_n = FILTER;
        cnt_n = '0;
      end
    endcase
  end
  always_ff @(posedge FAB_CLK) begin
    if (FAB_RST) begin
      LOCK_LOST <= 1'b0;
      LOSS_COUNT <= '0;
    end else if (loss) begin
      LOCK_LOST <= 1'b1;
      LOSS_COUNT <= CLR_LOSS ? LOSS_CNT_W'(1) : (&LOSS_COUNT ? LOSS_COUNT : LOSS_COUNT + 1'b1);
    end else if (CLR_LOSS) begin
      LOCK_LOST <= 1'b0;
      LOSS_COUNT <= '0;
    end
  end
endmodule

// File: tb/tb_fab_clk_lock_supervisor.sv
// tb_fab_clk_lock_supervisor: scoreboard bench against a lock-streak reference model
module tb_fab_clk_lock_supervisor;
  localparam int LF = 16;
  localparam int RH = 32;
  logic clk = 1'b0;
  logic rst_i, lock_i, byp_i, clr_i;
  logic sys_rst_a, sys_ready_a, lost_a, sys_rst_b, sys_ready_b, lost_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b, st_a, st_b;
  int compared = 0;
  int mismatched = 0;
  typedef struct {int st; int lost; int ca; int cb;} exp_t;
  exp_t q[$];
  bit hist0, hist1;
  int streak, m_lost, m_ca, m_cb;
  always #5 clk = ~clk;
  fab_clk_lock_supervisor dut (
    .FAB_CLK(clk), .FAB_RST(rst_i), .LOCK(lock_i), .BYPASS_LOCK(byp_i), .CLR_LOSS(clr_i),
    .SYS_RST(sys_rst_a), .SYS_READY(sys_ready_a), .LOCK_LOST(lost_a), .LOSS_COUNT(cnt_a), .STATE(st_a)
  );
  fab_clk_lock_supervisor #(.LOSS_CNT_W(2)) dut2 (
    .FAB_CLK(clk), .FAB_RST(rst_i), .LOCK(lock_i), .BYPASS_LOCK(byp_i), .CLR_LOSS(clr_i),
    .SYS_RST(sys_rst_b), .SYS_READY(sys_ready_b), .LOCK_LOST(lost_b), .LOSS_COUNT(cnt_b), .STATE(st_b)
  );
  function void chk(string name, int got, int want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    end
  endfunction
  task automatic step(input bit r, input bit l, input bit b, input bit c);
    exp_t e;
    bit ls, loss;
    rst_i = r;
    lock_i = l;
    byp_i = b;
    clr_i = c;
    if (r) begin
      hist0 = 0;
      hist1 = 0;
      streak = 0;
      m_lost = 0;
      m_ca = 0;
      m_cb = 0;
    end else begin
      ls = hist1;
      loss = !ls && streak >= LF + RH;
      streak = ls ? streak + 1 : 0;
      if (loss) begin
        m_lost = 1;
        m_ca = c ? 1 : (m_ca < 255 ? m_ca + 1 : 255);
        m_cb = c ? 1 : (m_cb < 3 ? m_cb + 1 : 3);
      end else if (c) begin
        m_lost = 0;
        m_ca = 0;
        m_cb = 0;
      end
      hist1 = hist0;
      hist0 = l | b;
    end
    e.st = streak >= LF + RH ? 2 : (streak >= LF ? 1 : 0);
    e.lost = m_lost;
    e.ca = m_ca;
    e.cb = m_cb;
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("state", int'(st_a), e.st);
      chk("sys_rst", int'(sys_rst_a), e.st != 2);
      chk("sys_ready", int'(sys_ready_a), e.st == 2);
      chk("lock_lost", int'(lost_a), e.lost);
      chk("loss_count", int'(cnt_a), e.ca);
      chk("state_w2", int'(st_b), e.st);
      chk("sys_rst_w2", int'(sys_rst_b), e.st != 2);
      chk("lock_lost_w2", int'(lost_b), e.lost);
      chk("loss_count_w2", int'(cnt_b), e.cb);
    end
  end
  initial begin
    int low_left;
    bit l;
    repeat (3) step(1, 1, 0, 0);
    repeat (60) step(0, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    repeat (60) step(0, 1, 0, 0);
    repeat (2) step(1, 1, 0, 0);
    for (int i = 0; i < 100; i++) step(0, i % 10 != 9, 0, 0);
    repeat (2) step(1, 1, 0, 0);
    repeat (30) step(0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    repeat (60) step(0, 1, 0, 0);
    repeat (2) step(1, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      repeat (55) step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, i == 5);
    end
    repeat (5) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    repeat (2) step(1, 0, 1, 0);
    repeat (55) step(0, 0, 1, 0);
    step(1, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    low_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (low_left > 0) begin
        l = 0;
        low_left--;
      end else if ($urandom_range(0, 59) == 0) begin
        l = 0;
        low_left = $urandom_range(0, 3);
      end else l = 1;
      step($urandom_range(0, 699) == 0, l, 0, $urandom_range(0, 39) == 0);
    end
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
